branch_train_tracker: RTL
=========================

# branch_train_tracker

Tracks in-flight gshare predictions between the predict and train ports of the branch predictor. Each prediction's pc, global history and predicted direction are buffered in order. When the branch resolves, the block issues the matching train request (pc, history, actual direction, mispredict flag). On a mispredict it flushes all younger, wrong-path entries.

## Interface
Parameters:
- N, 7, pc and history width
- DEPTH, 8, max outstanding predictions (power of 2, ≥2)

Ports:
- clk  in  1  clock, all state on rising edge
- areset_n  in  1  asynchronous, active-low reset
- pred_valid  in  1  prediction issued this cycle
- pred_ready  out  1  tracker can accept a prediction (not full)
- pred_pc  in  N  pc of predicted branch
- pred_history  in  N  history used for the prediction
- pred_taken  in  1  predicted direction
- resolve_valid  in  1  oldest outstanding branch resolved this cycle
- resolve_ready  out  1  an entry is outstanding (not empty)
- resolve_taken  in  1  actual direction
- train_valid  out  1  train request, single-cycle pulse
- train_taken  out  1  actual direction
- train_mispredicted  out  1  predicted ≠ actual
- train_history  out  N  history stored with the entry
- train_pc  out  N  pc stored with the entry
- count  out  $clog2(DEPTH)+1  entries outstanding

## Operation
- Push: pred_valid && pred_ready writes {pc, history, taken} at the tail.
- Pop: resolve_valid && resolve_ready reads the head entry.
  - mispredicted = head.taken ^ resolve_taken.
  - The train outputs load the head fields with resolve_taken and mispredicted.
- Flush: a pop with mispredicted=1 empties the tracker, so all younger entries are wrong-path.
  - A push in the same cycle as a flushing pop is discarded.
  - count is 0 the next cycle.
- A pop without mispredict in the same cycle as a push: count unchanged, and both take effect.
- pred_valid while !pred_ready: ignored, nothing written. The upstream stage must hold.
- resolve_valid while !resolve_ready: ignored, and train_valid stays 0.
- Pointers are log2(DEPTH)+1 bits with a wrap bit.
  - Full: pointers differ only in the MSB.
  - Empty: pointers are equal.
  - Wrap-around is silent.
- Flush sets head = tail; storage contents are don't-care.

## Timing
- Reset (asynchronous assert, synchronous release) forces:
  - count = 0
  - pred_ready = 1, resolve_ready = 0
  - train_valid = 0
  - train_taken, train_mispredicted, train_history, train_pc = 0
- pred_ready and resolve_ready are combinational from registered count only, with no input-to-output path.
- Train latency: train_* registered, asserted the cycle after the resolve handshake.
  - train_valid drops the following cycle unless another pop occurs.
  - Train data holds its last value while train_valid = 0.
- Back-to-back resolves give train_valid high on consecutive cycles.
- A push is visible to resolve the next cycle. There is no same-cycle bypass while empty.
- Reset mid-operation discards every entry and any train pulse in flight.

## Configuration
- BTT_STATS_EN defined: adds two outputs, each a 16-bit saturating counter reset to 0.
  - resolve_count, incremented per pop.
  - mispredict_count, incremented per flushing pop.
  - Both hold at 16'hFFFF when saturated.
- Undefined: these ports and counters do not exist. All other behaviour is identical.

## Structure
- Shared package branch_pkg holds:
  - the N default
  - the DEPTH default
  - typedef pred_entry_t {pc[N], history[N], taken}
- Sub-module btt_fifo: parameterised synchronous FIFO of pred_entry_t.
  - Ports: push, pop, flush, head data, count.
  - Contains pointer and full/empty logic only.
- The top level holds the mispredict compare, flush generation, train registers and the optional stats counters.

## Test plan
- Reset, then idle: count=0, pred_ready=1, resolve_ready=0, train_valid=0. Assert areset_n=0 mid-stream with 3 entries: count=0 at once.
- Push pc=0x12 hist=0x05 taken=1, then resolve_taken=1: next cycle train_valid=1, train_pc=0x12, train_history=0x05, train_taken=1, train_mispredicted=0, count=0.
- Push 3 entries, resolve the first with the opposite direction: train_mispredicted=1, count=0 next cycle, and a push in the flush cycle is lost.
- Push DEPTH=8 entries: pred_ready=0 and a 9th pred_valid is ignored. Resolve all 8 correctly: train pcs emerge in push order on 8 consecutive cycles.
- Steady simultaneous push and correct resolve across pointer wrap (20 cycles): count constant at 2, and no entry lost or duplicated.
- With BTT_STATS_EN: 5 correct and 2 mispredicted resolves give resolve_count=7, mispredict_count=2. Forced counters at 16'hFFFF stay saturated.

Source files
------------

// File: rtl/branch_pkg.sv
// branch_pkg: shared defaults and the buffered prediction record for branch_train_tracker.
package branch_pkg;
    localparam int BTT_N     = 7;
    localparam int BTT_DEPTH = 8;

    typedef struct packed {
        logic [BTT_N-1:0] pc;
        logic [BTT_N-1:0] history;
        logic             taken;
    } pred_entry_t;
endpackage

// File: rtl/btt_fifo.sv
// btt_fifo: in-order FIFO of prediction records with wrap-bit pointers and a head=tail flush.
module btt_fifo
    import branch_pkg::*;
#(
    parameter type T     = pred_entry_t,
    parameter int  DEPTH = BTT_DEPTH,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        areset_n,
    input  logic        push,
    input  logic        pop,
    input  logic        flush,
    input  T            wdata,
    output T            rdata,
    output logic [AW:0] count,
    output logic        full,
    output logic        empty
);
    T            mem [DEPTH];
    logic [AW:0] wptr_q, wptr_d, rptr_q, rptr_d;

    always_comb begin
        wptr_d = wptr_q + (AW+1)'(push);
        rptr_d = flush ? wptr_q : rptr_q + (AW+1)'(pop);
    end

    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    // Storage needs no reset: entries are only read while outstanding.
    always_ff @(posedge clk) begin
        if (push) mem[wptr_q[AW-1:0]] <= wdata;
    end

    assign rdata = mem[rptr_q[AW-1:0]];
    assign count = wptr_q - rptr_q;
    assign empty = wptr_q == rptr_q;
    assign full  = (wptr_q ^ rptr_q) == {1'b1, AW'(0)};
endmodule

// File: rtl/branch_train_tracker.sv
// branch_train_tracker: buffers gshare predictions and issues train requests on resolve, flushing on mispredict.
// Optional BTT_STATS_EN adds saturating resolve/mispredict counters.
module branch_train_tracker
    import branch_pkg::*;
#(
    parameter int  N     = BTT_N,
    parameter int  DEPTH = BTT_DEPTH,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic         clk,
    input  logic         areset_n,
    input  logic         pred_valid,
    output logic         pred_ready,
    input  logic [N-1:0] pred_pc,
    input  logic [N-1:0] pred_history,
    input  logic         pred_taken,
    input  logic         resolve_valid,
    output logic         resolve_ready,
    input  logic         resolve_taken,
    output logic         train_valid,
    output logic         train_taken,
    output logic         train_mispredicted,
    output logic [N-1:0] train_history,
    output logic [N-1:0] train_pc,
    output logic [AW:0]  count
`ifdef BTT_STATS_EN
   ,output logic [15:0]  resolve_count,
    output logic [15:0]  mispredict_count
`endif
);
    typedef struct packed {
        logic [N-1:0] pc;
        logic [N-1:0] history;
        logic         taken;
    } entry_t;

    entry_t       head, wdata;
    logic         full, empty, pop, mispred, push;
    logic         tvalid_q, tvalid_d, ttaken_q, ttaken_d, tmis_q, tmis_d;
    logic [N-1:0] tpc_q, tpc_d, thist_q, thist_d;

    assign pred_ready    = !full;
    assign resolve_ready = !empty;
    assign pop           = resolve_valid && !empty;
    assign mispred       = head.taken ^ resolve_taken;
    // A flushing pop discards any same-cycle push: it is wrong-path.
    assign push          = pred_valid && !full && !(pop && mispred);
    assign wdata         = '{pc: pred_pc, history: pred_history, taken: pred_taken};

    btt_fifo #(.T(entry_t), .DEPTH(DEPTH)) u_fifo (
        .clk      (clk),
        .areset_n (areset_n),
        .push     (push),
        .pop      (pop),
        .flush    (pop && mispred),
        .wdata    (wdata),
        .rdata    (head),
        .count    (count),
        .full     (full),
        .empty    (empty)
    );

    always_comb begin
        tvalid_d = pop;
        ttaken_d = pop ? resolve_taken : ttaken_q;
        tmis_d   = pop ? mispred : tmis_q;
        tpc_d    = pop ? head.pc : tpc_q;
        thist_d  = pop ? head.history : thist_q;
    end

    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            tvalid_q <= 1'b0;
            ttaken_q <= 1'b0;
            tmis_q   <= 1'b0;
            tpc_q    <= '0;
            thist_q  <= '0;
        end else begin
            tvalid_q <= tvalid_d;
            ttaken_q <= ttaken_d;
            tmis_q   <= tmis_d;
            tpc_q    <= tpc_d;
            thist_q  <= thist_d;
        end
    end

    assign train_valid        = tvalid_q;
    assign train_taken        = ttaken_q;
    assign train_mispredicted = tmis_q;
    assign train_pc           = tpc_q;
    assign train_history      = thist_q;

`ifdef BTT_STATS_EN
    logic [15:0] rcnt_q, rcnt_d, mcnt_q, mcnt_d;

    always_comb begin
        rcnt_d = (pop && rcnt_q != 16'hFFFF) ? rcnt_q + 16'd1 : rcnt_q;
        mcnt_d = (pop && mispred && mcnt_q != 16'hFFFF) ? mcnt_q + 16'd1 : mcnt_q;
    end

    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            rcnt_q <= '0;
            mcnt_q <= '0;
        end else begin
            rcnt_q <= rcnt_d;
            mcnt_q <= mcnt_d;
        end
    end

    assign resolve_count    = rcnt_q;
    assign mispredict_count = mcnt_q;
`endif
endmodule
